// File: rtl/tpu_drv_pkg.sv
// tpu_drv_pkg: opcodes, transaction sizes and FSM state shared by
// the TPU host driver (optional timeout: TPU_DRV_TIMEOUT_EN).
package tpu_drv_pkg;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD    = 3'b001;
  localparam logic [2:0] OP_COMPUTE = 3'b010;

  localparam int NUM_OPERANDS = 8;
  localparam int NUM_RESULTS  = 4;
  localparam int DONE_BIT     = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    WAIT_DONE,
    READ,
    EMIT
  } drv_state_t;

endpackage

// File: rtl/tpu_drv_result_capture.sv
// tpu_drv_result_capture: waits out the result skew, then shifts four
// TPU result bytes into a 32-bit word, lane 0 first.
module tpu_drv_result_capture
  import tpu_drv_pkg::*;
#(
  parameter int SKEW = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        active,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        last
);

  localparam int SW = (SKEW > 0) ? $clog2(SKEW + 1) : 1;

  logic [SW-1:0] skew_cnt;
  logic [1:0]    rd_cnt;
  logic          take;

  assign take = active && (skew_cnt == '0);
  assign last = take && (rd_cnt == 2'(NUM_RESULTS - 1));

  // new bytes enter at the top so c00 ends in lane 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skew_cnt <= '0;
      rd_cnt   <= '0;
      word     <= '0;
    end else if (start) begin
      skew_cnt <= SW'(SKEW);
      rd_cnt   <= '0;
    end else if (active) begin
      if (skew_cnt != '0) begin
        skew_cnt <= skew_cnt - 1'b1;
      end else begin
        word   <= {data, word[31:8]};
        rd_cnt <= rd_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/tpu_host_driver.sv
// tpu_host_driver: streams 8 operands into the 2x2 TPU, runs it and
// returns the 4 result bytes (optional timeout: TPU_DRV_TIMEOUT_EN).
module tpu_host_driver
  import tpu_drv_pkg::*;
#(
  parameter int RESULT_SKEW    = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic [7:0]  tpu_ui_in,
  output logic [7:0]  tpu_uio_in,
  input  logic [7:0]  tpu_uo_out,
  input  logic [7:0]  tpu_uio_out,
  output logic        error
);

  drv_state_t state;
  logic [3:0] load_cnt;
  logic [2:0] op;
  logic       done;
  logic       cap_start;
  logic       cap_active;
  logic       cap_last;
  logic       unused_status;

  assign tpu_uio_in    = {5'b00000, op};
  assign done          = tpu_uio_out[DONE_BIT];
  assign unused_status = ^tpu_uio_out[6:0];
  assign cap_start     = (state == WAIT_DONE) && done;
  assign cap_active    = (state == READ);

  tpu_drv_result_capture #(
    .SKEW (RESULT_SKEW)
  ) u_cap (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (cap_start),
    .active (cap_active),
    .data   (tpu_uo_out),
    .word   (m_data),
    .last   (cap_last)
  );

`ifdef TPU_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      busy      <= 1'b0;
      tpu_ui_in <= '0;
      op        <= OP_NOP;
      load_cnt  <= '0;
`ifdef TPU_DRV_TIMEOUT_EN
      tmo_cnt   <= '0;
      error     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          s_ready <= 1'b1;
          op      <= OP_NOP;
          if (s_valid && s_ready) begin
            tpu_ui_in <= s_data;
            op        <= OP_LOAD;
            load_cnt  <= 4'd1;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          // an idle stream cycle must not advance the TPU load address
          if (s_valid && s_ready) begin
            tpu_ui_in <= s_data;
            op        <= OP_LOAD;
            load_cnt  <= load_cnt + 4'd1;
            if (load_cnt == 4'(NUM_OPERANDS - 1)) begin
              s_ready <= 1'b0;
              state   <= COMPUTE;
            end
          end else begin
            op <= OP_NOP;
          end
        end
        COMPUTE: begin
          op    <= OP_COMPUTE;
          state <= WAIT_DONE;
`ifdef TPU_DRV_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT_DONE: begin
          op <= OP_NOP;
          if (done) begin
            state <= READ;
`ifdef TPU_DRV_TIMEOUT_EN
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        READ: begin
          if (cap_last) begin
            m_valid <= 1'b1;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_driver.sv
// tb_tpu_host_driver: two drivers (result skew 0 and 2), each wired to
// a behavioural 2x2 TPU model, checked against a matrix-product reference.
module tb_tpu_host_driver;

  logic        clk;
  logic        rst_n       [2];
  logic [7:0]  s_data      [2];
  logic        s_valid     [2];
  logic        s_ready     [2];
  logic [31:0] m_data      [2];
  logic        m_valid     [2];
  logic        m_ready     [2];
  logic        busy        [2];
  logic        error       [2];
  logic [7:0]  tpu_ui_in   [2];
  logic [7:0]  tpu_uio_in  [2];
  logic [7:0]  tpu_uo_out  [2];
  logic [7:0]  tpu_uio_out [2];

  int total;
  int bad;
  int dl       [2];
  int phase    [2];
  int loads    [2];
  int computes [2];
  int badops   [2];
  logic [2:0] addr [2];
  logic [7:0] mem  [2][8];
  logic [7:0] res  [2][4];
  logic [7:0] op   [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tpu_host_driver #(
      .RESULT_SKEW    (2 * g),
      .TIMEOUT_CYCLES (20)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .s_data      (s_data[g]),
      .s_valid     (s_valid[g]),
      .s_ready     (s_ready[g]),
      .m_data      (m_data[g]),
      .m_valid     (m_valid[g]),
      .m_ready     (m_ready[g]),
      .busy        (busy[g]),
      .tpu_ui_in   (tpu_ui_in[g]),
      .tpu_uio_in  (tpu_uio_in[g]),
      .tpu_uo_out  (tpu_uo_out[g]),
      .tpu_uio_out (tpu_uio_out[g]),
      .error       (error[g])
    );
  end

  // TPU model: loads bytes at an auto-incrementing address, then raises
  // done dl cycles after COMPUTE and presents c00..c11 after the skew
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        phase[k] <= -1;
        addr[k]  <= '0;
      end else begin
        if (tpu_uio_in[k][7:3] != 5'd0 || tpu_uio_in[k][2:0] > 3'd2)
          badops[k] <= badops[k] + 1;
        if (phase[k] >= 0) phase[k] <= phase[k] + 1;
        if (tpu_uio_in[k][2:0] == 3'd1) begin
          mem[k][addr[k]] <= tpu_ui_in[k];
          addr[k]  <= addr[k] + 3'd1;
          phase[k] <= -1;
          loads[k] <= loads[k] + 1;
        end else if (tpu_uio_in[k][2:0] == 3'd2) begin
          res[k][0] <= 8'(mem[k][0] * mem[k][4] + mem[k][1] * mem[k][6]);
          res[k][1] <= 8'(mem[k][0] * mem[k][5] + mem[k][1] * mem[k][7]);
          res[k][2] <= 8'(mem[k][2] * mem[k][4] + mem[k][3] * mem[k][6]);
          res[k][3] <= 8'(mem[k][2] * mem[k][5] + mem[k][3] * mem[k][7]);
          addr[k]     <= '0;
          phase[k]    <= 0;
          computes[k] <= computes[k] + 1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      tpu_uo_out[k] = 8'hA5;
      for (int j = 0; j < 4; j++)
        if (phase[k] == dl[k] + 1 + 2 * k + j) tpu_uo_out[k] = res[k][j];
      tpu_uio_out[k] = {(phase[k] >= 0) && (phase[k] >= dl[k]), 7'h55};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // C = W x X, W and X row-major; returns {c11,c10,c01,c00} low bytes
  function automatic logic [31:0] ref_word(input logic [7:0] o [8]);
    logic [31:0] w;
    int acc;
    w = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc = 0;
        for (int l = 0; l < 2; l++)
          acc += int'(o[i * 2 + l]) * int'(o[4 + l * 2 + j]);
        w[(i * 2 + j) * 8 +: 8] = acc[7:0];
      end
    return w;
  endfunction

  task automatic chk_reset(input int k, input string tag);
    chk({tag, "_ctl"}, 32'({s_ready[k], m_valid[k], busy[k], error[k]}), 32'd0);
    chk({tag, "_pins"}, {16'd0, tpu_ui_in[k], tpu_uio_in[k]}, 32'd0);
    chk({tag, "_data"}, m_data[k], 32'd0);
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
  task automatic send_ops(input int k, input logic [7:0] o [8], input int mode);
    int i;
    int n;
    bit v;
    bit acc;
    i = 0;
    n = 0;
    @(posedge clk);
    #1;
    while (i < 8 && n < 400) begin
      case (mode)
        0: v = 1'b1;
        1: v = (n % 2 == 0);
        default: v = ($urandom_range(99) >= 30);
      endcase
      s_valid[k] = v;
      s_data[k]  = v ? o[i] : 8'($urandom);
      @(negedge clk);
      acc = s_valid[k] && s_ready[k];
      @(posedge clk);
      #1;
      if (acc) i++;
      n++;
    end
    s_valid[k] = 1'b0;
    chk("accepted", 32'(i), 32'd8);
    chk("s_ready_drop", 32'(s_ready[k]), 32'd0);
  endtask

  task automatic collect(input int k, input logic [31:0] exp, input int hold,
                         input int l0, input int c0);
    int n;
    bit stable;
    m_ready[k] = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!m_valid[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("valid_bound", 32'(n < 300), 32'd1);
    stable = 1'b1;
    for (int c = 0; c < hold; c++) begin
      if (m_data[k] !== exp || !m_valid[k] || s_ready[k]) stable = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
    chk("m_data", m_data[k], exp);
    m_ready[k] = 1'b1;
    @(negedge clk);
    m_ready[k] = 1'b0;
    chk("emit_drop", 32'({m_valid[k], busy[k]}), 32'd0);
    chk("load_ops", 32'(loads[k] - l0), 32'd8);
    chk("compute_ops", 32'(computes[k] - c0), 32'd1);
  endtask

  task automatic run_txn(input int k, input logic [7:0] o [8], input int mode,
                         input int hold);
    int l0;
    int c0;
    l0 = loads[k];
    c0 = computes[k];
    send_ops(k, o, mode);
    collect(k, ref_word(o), hold, l0, c0);
  endtask

  initial begin
    int n;
    bit saw;
    clk = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k]   = 1'b0;
      s_valid[k] = 1'b0;
      s_data[k]  = '0;
      m_ready[k] = 1'b0;
      dl[k]      = 3;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk_reset(k, "reset");
    for (int k = 0; k < 2; k++) rst_n[k] = 1'b1;

    op = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    chk("ref_sanity", ref_word(op), 32'h322B1613);
    run_txn(0, op, 0, 0);
    run_txn(0, op, 1, 0);

    for (int i = 0; i < 8; i++) op[i] = 8'($urandom);
    run_txn(0, op, 0, 10);

    dl[0] = 50;
    send_ops(0, op, 0);
    repeat (4) @(negedge clk);
    chk("wait_busy", 32'({busy[0], m_valid[0]}), 32'd2);
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk_reset(0, "midreset");
    rst_n[0] = 1'b1;
    dl[0] = 2;
    for (int i = 0; i < 8; i++) op[i] = 8'($urandom);
    run_txn(0, op, 0, 0);

    op = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    dl[1] = 1;
    run_txn(1, op, 0, 0);

    for (int t = 0; t < 12; t++) begin
      int k;
      k = t % 2;
      for (int i = 0; i < 8; i++) op[i] = 8'($urandom);
      dl[k] = $urandom_range(6);
      run_txn(k, op, (t % 3 == 0) ? 0 : 2, $urandom_range(3));
    end

`ifdef TPU_DRV_TIMEOUT_EN
    dl[0] = 100000;
    for (int i = 0; i < 8; i++) op[i] = 8'($urandom);
    send_ops(0, op, 0);
    n = 0;
    saw = 1'b0;
    @(negedge clk);
    while (busy[0] && n < 200) begin
      n++;
      saw |= m_valid[0];
      @(negedge clk);
    end
    chk("timeout_cycles", 32'(n), 32'd21);
    chk("timeout_flags", 32'({error[0], saw, s_ready[0]}), 32'd5);
`else
    n = 0;
    saw = 1'b0;
    chk("error_tied", 32'({error[0], error[1]}), 32'd0);
`endif

    for (int k = 0; k < 2; k++) chk("bad_ops", 32'(badops[k]), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpu_host_driver.md
Name: tpu_host_driver

Overview:
Host-side master for the 2x2 TPU pin protocol; drives the TPU's data and instruction pins and consumes its result and done pins.
- Accepts 8 operand bytes on a valid/ready stream: 4 weights, then 4 inputs, element order 00, 01, 10, 11.
- Sequences the load and compute instructions, waits for done, then captures the 4 result low-bytes.
- Returns the results as one 32-bit word on a valid/ready stream.
- Sits in the test harness / companion-FPGA side, wired pin-to-pin to the TPU top.

Parameters:
- RESULT_SKEW, 0: cycles between first sampling done=1 and capturing result c00.
- TIMEOUT_CYCLES, 255: maximum WAIT_DONE cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- s_data  in  8  operand byte.
- s_valid  in  1  operand byte valid.
- s_ready  out  1  driver accepts a byte this cycle.
- m_data  out  32  results {c11,c10,c01,c00}, low byte of each accumulation.
- m_valid  out  1  result word valid.
- m_ready  in  1  consumer accepts the result word.
- busy  out  1  high in any state other than IDLE.
- tpu_ui_in  out  8  drives the TPU data pins.
- tpu_uio_in  out  8  drives the TPU instruction pins; bits [7:3] are always 0.
- tpu_uo_out  in  8  TPU result byte.
- tpu_uio_out  in  8  TPU status pins; bit 7 is done, other bits ignored.
- error  out  1  sticky timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n low at a clk edge), all outputs registered:
  - s_ready=0, m_valid=0, m_data=0, busy=0, error=0.
  - tpu_ui_in=0, tpu_uio_in = OP_NOP.
  - State IDLE, all counters 0.
  - Reset mid-transaction abandons it; no partial result is emitted.
- FSM states: IDLE, LOAD, COMPUTE, WAIT_DONE, READ, EMIT.
- IDLE:
  - s_ready=1.
  - On s_valid & s_ready: register the byte onto tpu_ui_in, set tpu_uio_in = OP_LOAD, set load_cnt=1, go to LOAD.
- LOAD:
  - s_ready=1; each accepted byte is registered to tpu_ui_in with OP_LOAD, and load_cnt increments.
  - A cycle with no s_valid drives OP_NOP; the TPU's address does not advance.
  - Exactly 8 OP_LOAD cycles are issued per transaction.
  - After the 8th byte is accepted, s_ready drops the next cycle; go to COMPUTE.
- COMPUTE: drive OP_COMPUTE for exactly one cycle, then OP_NOP; go to WAIT_DONE.
- WAIT_DONE:
  - Drive OP_NOP.
  - When tpu_uio_out[7]=1 is sampled, load skew_cnt=RESULT_SKEW and go to READ.
  - A done already high on entry counts as done.
- READ:
  - After skew_cnt reaches 0, sample tpu_uo_out on 4 consecutive cycles into byte lanes 0..3 of m_data.
  - Then set m_valid=1 and go to EMIT.
- EMIT:
  - Hold m_data and m_valid stable until m_valid & m_ready; then m_valid=0 the next cycle and return to IDLE.
  - If m_ready is already high when m_valid rises, the handshake completes on that cycle.
- s_valid is ignored outside IDLE/LOAD; no new operand is accepted until the result is consumed. At most one transaction is in flight.
- Latency: first byte accepted -> m_valid = 8 (load, if streamed back-to-back) + 1 (compute) + done latency + RESULT_SKEW + 4 cycles.
- Counters: load_cnt is 4 bits and saturates at 8; rd_cnt is 2 bits and wraps after lane 3 only on READ exit.

Optional Feature:
- Macro TPU_DRV_TIMEOUT_EN.
- Defined:
  - A WAIT_DONE cycle counter (width clog2(TIMEOUT_CYCLES+1)) runs.
  - On reaching TIMEOUT_CYCLES without done: set error=1 (sticky until reset), drive OP_NOP, go to IDLE with no m_valid.
  - Done in the same cycle as expiry wins (go to READ).
- Not defined: no counter; WAIT_DONE waits indefinitely; error is tied 0.

Decomposition:
- Package tpu_drv_pkg holds:
  - Opcode constants OP_NOP=3'b000, OP_LOAD=3'b001, OP_COMPUTE=3'b010.
  - NUM_OPERANDS=8, NUM_RESULTS=4.
  - The FSM state enum.
  - DONE_BIT=7.
- One natural sub-module, tpu_drv_result_capture: a skew counter plus a 4-lane byte shift register producing the 32-bit word and a capture-complete strobe.

Test Plan:
1. Stream weights 1,2,3,4 and inputs 5,6,7,8 back-to-back; bench TPU model asserts done and returns 19,22,43,50 -> m_data=0x322B1613 and exactly 8 OP_LOAD cycles.
2. s_valid gapped every other cycle -> OP_NOP on each gap cycle, 8 OP_LOAD total, same result as scenario 1.
3. Hold m_ready=0 for 10 cycles after m_valid -> m_data stable and s_ready=0 throughout; accepted on the first m_ready=1, then back to IDLE.
4. rst_n low during WAIT_DONE -> next cycle all outputs at reset values; a fresh transaction then completes correctly.
5. RESULT_SKEW=2 with model results delayed 2 cycles after done -> correct m_data.
6. With TPU_DRV_TIMEOUT_EN, TIMEOUT_CYCLES=20, done never asserted -> error=1 after 20 WAIT_DONE cycles, m_valid never set, state IDLE.
